// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port general-purpose register file with busy scoreboard.
//
// NRD combinational read ports, two write ports (port 1 wins on a same-address
// collision), optional same-cycle write-to-read bypass and a per-register busy
// bit (set at issue, cleared at writeback; a same-edge issue wins over the clear).
//
// Ports:
//   clk, rstB                  clock; synchronous active-low reset
//   wr0En/wr0Addr/wr0Data      write port 0
//   wr1En/wr1Addr/wr1Data      write port 1 (priority)
//   rdAddr  [NRD*AW]           packed read addresses, port i = [i*AW +: AW]
//   rdData  [NRD*XLEN]         packed read data,      port i = [i*XLEN +: XLEN]
//   rdBusy  [NRD]              busy flag of the register on each read port
//   issueEn/issueAddr          claim a register as having an in-flight producer
//   busyVec [NREGS]            full scoreboard
module reg_file_mp #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NRD     = 2,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rstB,
  input  logic                wr0En,
  input  logic [AW-1:0]       wr0Addr,
  input  logic [XLEN-1:0]     wr0Data,
  input  logic                wr1En,
  input  logic [AW-1:0]       wr1Addr,
  input  logic [XLEN-1:0]     wr1Data,
  input  logic [NRD*AW-1:0]   rdAddr,
  output logic [NRD*XLEN-1:0] rdData,
  output logic [NRD-1:0]      rdBusy,
  input  logic                issueEn,
  input  logic [AW-1:0]       issueAddr,
  output logic [NREGS-1:0]    busyVec
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  // Address is backed by a real, writable register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wr0_ok;
  logic wr1_ok;
  logic iss_ok;
  logic byp_en;

  always_comb begin
    wr0_ok = wr0En && addr_ok(wr0Addr);
    wr1_ok = wr1En && addr_ok(wr1Addr);
    iss_ok = issueEn && addr_ok(issueAddr);
    // Bypass is suppressed in the reset cycle: writes are dropped then.
    byp_en = (BYPASS != 0) && rstB;
  end

  // Reset is folded into the next-state logic so the flops stay plain.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (!rstB) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_d[r] = '0;
      end
      busy_d = '0;
    end else begin
      if (wr0_ok) regs_d[wr0Addr] = wr0Data;
      if (wr1_ok) regs_d[wr1Addr] = wr1Data;
      if (wr0_ok) busy_d[wr0Addr] = 1'b0;
      if (wr1_ok) busy_d[wr1Addr] = 1'b0;
      // Applied last: a new producer outranks the writeback clearing it.
      if (iss_ok) busy_d[issueAddr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    busy_q <= busy_d;
  end

  always_comb begin
    logic [AW-1:0] ra;
    logic          hit0;
    logic          hit1;
    rdData = '0;
    rdBusy = '0;
    ra     = '0;
    hit0   = 1'b0;
    hit1   = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra   = rdAddr[i*AW +: AW];
      hit1 = byp_en && wr1_ok && (wr1Addr == ra);
      hit0 = byp_en && wr0_ok && (wr0Addr == ra);
      if (hit1) begin
        rdData[i*XLEN +: XLEN] = wr1Data;
      end else if (hit0) begin
        rdData[i*XLEN +: XLEN] = wr0Data;
      end else if (addr_ok(ra)) begin
        rdData[i*XLEN +: XLEN] = regs_q[ra];
      end
      // A bypassed value is the producer's result, so it is no longer pending.
      rdBusy[i] = !(hit0 || hit1) && addr_ok(ra) && busy_q[ra];
    end
  end

  assign busyVec = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed scoreboard bench for reg_file_mp.
// Instances: A (defaults, bypass), B (no bypass), sharing stimulus;
// C (NREGS=16, NRD=3, XLEN=64); D (NREGS=12, NRD=1, XLEN=8, ZERO_R0=0).
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rstB;
  always #5 clk = ~clk;

  // A/B shared stimulus
  logic        w0en, w1en, issen;
  logic [4:0]  w0a, w1a, issa;
  logic [31:0] w0d, w1d;
  logic [9:0]  rda;
  logic [63:0] a_rdd, b_rdd;
  logic [1:0]  a_rdb, b_rdb;
  logic [31:0] a_bv, b_bv;

  // C
  logic         c_w0en, c_w1en, c_iss;
  logic [3:0]   c_w0a, c_w1a, c_issa;
  logic [63:0]  c_w0d, c_w1d;
  logic [11:0]  c_rda;
  logic [191:0] c_rdd;
  logic [2:0]   c_rdb;
  logic [15:0]  c_bv;

  // D
  logic        d_w0en, d_w1en, d_iss;
  logic [3:0]  d_w0a, d_w1a, d_issa, d_rda;
  logic [7:0]  d_w0d, d_w1d, d_rdd;
  logic [0:0]  d_rdb;
  logic [11:0] d_bv;

  reg_file_mp u_a (
    .clk(clk), .rstB(rstB),
    .wr0En(w0en), .wr0Addr(w0a), .wr0Data(w0d),
    .wr1En(w1en), .wr1Addr(w1a), .wr1Data(w1d),
    .rdAddr(rda), .rdData(a_rdd), .rdBusy(a_rdb),
    .issueEn(issen), .issueAddr(issa), .busyVec(a_bv)
  );

  reg_file_mp #(.BYPASS(0)) u_b (
    .clk(clk), .rstB(rstB),
    .wr0En(w0en), .wr0Addr(w0a), .wr0Data(w0d),
    .wr1En(w1en), .wr1Addr(w1a), .wr1Data(w1d),
    .rdAddr(rda), .rdData(b_rdd), .rdBusy(b_rdb),
    .issueEn(issen), .issueAddr(issa), .busyVec(b_bv)
  );

  reg_file_mp #(.XLEN(64), .NREGS(16), .NRD(3)) u_c (
    .clk(clk), .rstB(rstB),
    .wr0En(c_w0en), .wr0Addr(c_w0a), .wr0Data(c_w0d),
    .wr1En(c_w1en), .wr1Addr(c_w1a), .wr1Data(c_w1d),
    .rdAddr(c_rda), .rdData(c_rdd), .rdBusy(c_rdb),
    .issueEn(c_iss), .issueAddr(c_issa), .busyVec(c_bv)
  );

  reg_file_mp #(.XLEN(8), .NREGS(12), .NRD(1), .ZERO_R0(0)) u_d (
    .clk(clk), .rstB(rstB),
    .wr0En(d_w0en), .wr0Addr(d_w0a), .wr0Data(d_w0d),
    .wr1En(d_w1en), .wr1Addr(d_w1a), .wr1Data(d_w1d),
    .rdAddr(d_rda), .rdData(d_rdd), .rdBusy(d_rdb),
    .issueEn(d_iss), .issueAddr(d_issa), .busyVec(d_bv)
  );

  typedef enum int unsigned {
    A_RD, A_BSY, A_BV, B_RD, B_BSY, B_BV, C_RD, C_BV, D_RD, D_BSY, D_BV
  } obs_e;

  typedef struct {
    string       tag;
    obs_e        sel;
    int unsigned port;
    logic [63:0] exp;
  } sb_t;

  sb_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input obs_e sel, input int unsigned port);
    logic [63:0] v;
    v = '0;
    case (sel)
      A_RD:  v[31:0] = a_rdd[port*32 +: 32];
      A_BSY: v[1:0]  = a_rdb;
      A_BV:  v[31:0] = a_bv;
      B_RD:  v[31:0] = b_rdd[port*32 +: 32];
      B_BSY: v[1:0]  = b_rdb;
      B_BV:  v[31:0] = b_bv;
      C_RD:  v       = c_rdd[port*64 +: 64];
      C_BV:  v[15:0] = c_bv;
      D_RD:  v[7:0]  = d_rdd;
      D_BSY: v[0]    = d_rdb[0];
      D_BV:  v[11:0] = d_bv;
      default: v = '1;
    endcase
    return v;
  endfunction

  task automatic sb_push(input string tag, input obs_e sel, input int unsigned port,
                         input logic [63:0] exp);
    sb_t e;
    e.tag = tag; e.sel = sel; e.port = port; e.exp = exp;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle mid-cycle, then compare everything queued.
  task automatic settle_drain();
    sb_t e;
    #3;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel, e.port), e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w0en = 1'b0; w1en = 1'b0; issen = 1'b0;
    c_w0en = 1'b0; c_w1en = 1'b0; c_iss = 1'b0;
    d_w0en = 1'b0; d_w1en = 1'b0; d_iss = 1'b0;
  endtask

  initial begin
    rstB = 1'b0;
    idle();
    w0a = '0; w1a = '0; issa = '0; w0d = '0; w1d = '0; rda = '0;
    c_w0a = '0; c_w1a = '0; c_issa = '0; c_w0d = '0; c_w1d = '0; c_rda = '0;
    d_w0a = '0; d_w1a = '0; d_issa = '0; d_w0d = '0; d_w1d = '0; d_rda = '0;

    cyc();
    rstB = 1'b1;
    sb_push("rst_a_bv", A_BV, 0, 64'h0);
    sb_push("rst_b_bv", B_BV, 0, 64'h0);
    sb_push("rst_a_rd", A_RD, 0, 64'h0);
    sb_push("rst_c_bv", C_BV, 0, 64'h0);
    sb_push("rst_d_bv", D_BV, 0, 64'h0);
    settle_drain();

    // Write x5, then reset with a write and issue that must be ignored.
    w0en = 1'b1; w0a = 5'd5; w0d = 32'hDEADBEEF; rda = {5'd0, 5'd5};
    sb_push("x5_byp_a", A_RD, 0, 64'hDEADBEEF);
    sb_push("x5_nobyp_b", B_RD, 0, 64'h0);
    settle_drain();
    cyc(); idle();
    sb_push("x5_a", A_RD, 0, 64'hDEADBEEF);
    sb_push("x5_b", B_RD, 0, 64'hDEADBEEF);
    settle_drain();

    rstB = 1'b0;
    w1en = 1'b1; w1a = 5'd6; w1d = 32'h1111; issen = 1'b1; issa = 5'd6;
    rda = {5'd6, 5'd5};
    sb_push("inrst_x5_a", A_RD, 0, 64'hDEADBEEF);
    sb_push("inrst_nobyp_a", A_RD, 1, 64'h0);
    sb_push("inrst_bsy_a", A_BSY, 0, 64'h0);
    settle_drain();
    cyc(); idle(); rstB = 1'b1;
    sb_push("postrst_x5_a", A_RD, 0, 64'h0);
    sb_push("postrst_x5_b", B_RD, 0, 64'h0);
    sb_push("postrst_x6_a", A_RD, 1, 64'h0);
    sb_push("postrst_bv_a", A_BV, 0, 64'h0);
    sb_push("postrst_bv_b", B_BV, 0, 64'h0);
    settle_drain();

    // r0 is hardwired zero and never busy.
    w0en = 1'b1; w0a = 5'd0; w0d = 32'h1234; issen = 1'b1; issa = 5'd0; rda = '0;
    sb_push("r0_byp_a", A_RD, 0, 64'h0);
    sb_push("r0_bsy_a", A_BSY, 0, 64'h0);
    settle_drain();
    cyc(); idle();
    sb_push("r0_a", A_RD, 0, 64'h0);
    sb_push("r0_bv_a", A_BV, 0, 64'h0);
    sb_push("r0_b", B_RD, 1, 64'h0);
    settle_drain();

    // Collision on x7: port 1 wins.
    w0en = 1'b1; w0a = 5'd7; w0d = 32'hAAAA;
    w1en = 1'b1; w1a = 5'd7; w1d = 32'h5555; rda = {5'd7, 5'd7};
    sb_push("coll_byp_a", A_RD, 0, 64'h5555);
    sb_push("coll_nobyp_b", B_RD, 0, 64'h0);
    settle_drain();
    cyc(); idle();
    sb_push("coll_a", A_RD, 1, 64'h5555);
    sb_push("coll_b", B_RD, 0, 64'h5555);
    settle_drain();

    // Bypass from each write port on separate read ports.
    w1en = 1'b1; w1a = 5'd3; w1d = 32'h77;
    w0en = 1'b1; w0a = 5'd4; w0d = 32'h44; rda = {5'd4, 5'd3};
    sb_push("byp1_a", A_RD, 0, 64'h77);
    sb_push("byp0_a", A_RD, 1, 64'h44);
    sb_push("byp1_b", B_RD, 0, 64'h0);
    sb_push("byp0_b", B_RD, 1, 64'h0);
    settle_drain();
    cyc(); idle();
    sb_push("late1_b", B_RD, 0, 64'h77);
    sb_push("late0_b", B_RD, 1, 64'h44);
    settle_drain();

    // Scoreboard: issue x9, then writeback clears it.
    issen = 1'b1; issa = 5'd9; rda = {5'd0, 5'd9};
    sb_push("iss_same_bv_a", A_BV, 0, 64'h0);
    settle_drain();
    cyc(); idle();
    sb_push("iss_bv_a", A_BV, 0, 64'h200);
    sb_push("iss_bsy_a", A_BSY, 0, 64'h1);
    sb_push("iss_bsy_b", B_BSY, 0, 64'h1);
    sb_push("iss_bv_b", B_BV, 0, 64'h200);
    settle_drain();

    w0en = 1'b1; w0a = 5'd9; w0d = 32'h99; rda = {5'd9, 5'd9};
    sb_push("wb_fwd_bsy_a", A_BSY, 0, 64'h0);
    sb_push("wb_fwd_a", A_RD, 0, 64'h99);
    sb_push("wb_bsy_b", B_BSY, 0, 64'h3);
    sb_push("wb_old_b", B_RD, 0, 64'h0);
    settle_drain();
    cyc(); idle();
    sb_push("wb_bv_a", A_BV, 0, 64'h0);
    sb_push("wb_bv_b", B_BV, 0, 64'h0);
    sb_push("wb_b", B_RD, 1, 64'h99);
    settle_drain();

    issen = 1'b1; issa = 5'd9; w1en = 1'b1; w1a = 5'd9; w1d = 32'h9A;
    settle_drain();
    cyc(); idle();
    sb_push("isswr_bv_a", A_BV, 0, 64'h200);
    sb_push("isswr_a", A_RD, 0, 64'h9A);
    sb_push("isswr_b", B_RD, 0, 64'h9A);
    sb_push("isswr_bsy_a", A_BSY, 0, 64'h3);
    settle_drain();

    issen = 1'b1; issa = 5'd10; w0en = 1'b1; w0a = 5'd9; w0d = 32'h9B;
    settle_drain();
    cyc(); idle();
    sb_push("iss10_bv_a", A_BV, 0, 64'h400);
    sb_push("iss10_bv_b", B_BV, 0, 64'h400);
    sb_push("iss10_x9_a", A_RD, 1, 64'h9B);
    sb_push("iss10_bsy_a", A_BSY, 0, 64'h0);
    settle_drain();

    // C: wide data, three read ports, top register.
    c_w1en = 1'b1; c_w1a = 4'd15; c_w1d = 64'h0123456789ABCDEF;
    c_rda = {4'd15, 4'd15, 4'd15};
    for (int unsigned p = 0; p < 3; p++) sb_push("c_byp", C_RD, p, 64'h0123456789ABCDEF);
    settle_drain();
    cyc(); idle();
    for (int unsigned p = 0; p < 3; p++) sb_push("c_x15", C_RD, p, 64'h0123456789ABCDEF);
    sb_push("c_bv0", C_BV, 0, 64'h0);
    settle_drain();

    c_w0en = 1'b1; c_w0a = 4'd15; c_w0d = 64'hFEDCBA9876543210;
    c_w1en = 1'b1; c_w1a = 4'd0; c_w1d = 64'h1;
    c_iss = 1'b1; c_issa = 4'd15; c_rda = {4'd15, 4'd0, 4'd15};
    sb_push("c_byp0_p0", C_RD, 0, 64'hFEDCBA9876543210);
    sb_push("c_r0_p1", C_RD, 1, 64'h0);
    settle_drain();
    cyc(); idle();
    sb_push("c_p0", C_RD, 0, 64'hFEDCBA9876543210);
    sb_push("c_p1", C_RD, 1, 64'h0);
    sb_push("c_p2", C_RD, 2, 64'hFEDCBA9876543210);
    sb_push("c_bv15", C_BV, 0, 64'h8000);
    settle_drain();

    // D: out-of-range addresses ignored; r0 is ordinary storage.
    d_w0en = 1'b1; d_w0a = 4'd0; d_w0d = 8'h5A;
    d_w1en = 1'b1; d_w1a = 4'd13; d_w1d = 8'hEE;
    d_iss = 1'b1; d_issa = 4'd14; d_rda = 4'd13;
    sb_push("d_oob_byp", D_RD, 0, 64'h0);
    sb_push("d_oob_bsy", D_BSY, 0, 64'h0);
    settle_drain();
    cyc(); idle();
    sb_push("d_oob_rd", D_RD, 0, 64'h0);
    sb_push("d_oob_bv", D_BV, 0, 64'h0);
    settle_drain();
    d_rda = 4'd0;
    sb_push("d_r0", D_RD, 0, 64'h5A);
    settle_drain();

    d_iss = 1'b1; d_issa = 4'd0; d_w1en = 1'b1; d_w1a = 4'd11; d_w1d = 8'hC3;
    settle_drain();
    cyc(); idle();
    sb_push("d_r0_bv", D_BV, 0, 64'h1);
    sb_push("d_r0_bsy", D_BSY, 0, 64'h1);
    settle_drain();
    d_rda = 4'd11;
    sb_push("d_x11", D_RD, 0, 64'hC3);
    settle_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
